fir_4pe_scheduler: RTL and testbench

Sequencing controller for the four-PE 2-D FIR array (`fir_filter_2d` ×4, horizontal image bands). It drives the shared `tc_set` / `valid_dmac` controls. On `start` it loads the nine filter taps, then walks every (row, column) position of one band, stalling on the window fetcher. Each PE result is captured one `PE_LAT` window after issue. It sits between the window-fetch unit (which builds the 3×3 crops for all four bands) and the output sink that writes the right half of the double-width output frame.

---
 rtl/fir_sched_pkg.sv | 22 ++
 rtl/fir_pos_counter.sv | 35 +++
 rtl/fir_4pe_scheduler.sv | 103 ++++++++++
 tb/tb_fir_4pe_scheduler.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fir_sched_pkg.sv
// fir_sched_pkg: shared state encoding, default geometry and width helpers for fir_4pe_scheduler
package fir_sched_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, CAPTURE, DONE} state_t;

    localparam int DEF_IMG_W  = 1920;
    localparam int DEF_IMG_H  = 1080;
    localparam int DEF_NUM_PE = 4;
    localparam int DEF_PE_H   = 270;
    localparam int DEF_TAPS   = 9;
    localparam int DEF_PE_LAT = 1;

    // Counter width for a range of n values; never below one bit.
    function automatic int cw(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    localparam int ROW_W = cw(DEF_PE_H);
    localparam int COL_W = cw(DEF_IMG_W);
    localparam int TAP_W = 4;

endpackage

// File: rtl/fir_pos_counter.sv
// fir_pos_counter: column/row raster counter for one band.
// Ports: clk, rst (sync, active-high), clr (restart at 0,0), inc (advance one position),
//        col/row (current position), last (at final position of the band).
module fir_pos_counter #(
    parameter int W  = 4,
    parameter int H  = 2,
    parameter int CW = 2,
    parameter int RW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last
);

    logic col_end, row_end;

    assign col_end = col == CW'(W - 1);
    assign row_end = row == RW'(H - 1);
    assign last    = col_end && row_end;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            col <= '0;
            row <= '0;
        end else if (inc) begin
            col <= col_end ? '0 : col + 1'b1;
            row <= col_end ? (row_end ? '0 : row + 1'b1) : row;
        end
    end

endmodule

// File: rtl/fir_4pe_scheduler.sv
// fir_4pe_scheduler: tap-load and raster sequencer for the four-PE 2-D FIR array.
// Ports: clk, rst (sync, active-high), start, win_valid in; tc_set, tap_idx, valid_dmac,
//        row, col, out_we, busy, done out.
// FIR_SCHED_PERF_EN adds perf_cycles (cycles spent in a frame) and perf_stalls
// (ISSUE cycles without a window), both saturating and cleared on start/rst.
module fir_4pe_scheduler
    import fir_sched_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int NUM_PE = DEF_NUM_PE,
    parameter int PE_H   = DEF_PE_H,
    parameter int TAPS   = DEF_TAPS,
    parameter int PE_LAT = DEF_PE_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  win_valid,
    output logic                  tc_set,
    output logic [TAP_W-1:0]      tap_idx,
    output logic                  valid_dmac,
    output logic [cw(PE_H)-1:0]   row,
    output logic [cw(IMG_W)-1:0]  col,
    output logic                  out_we,
    output logic                  busy,
    output logic                  done
`ifdef FIR_SCHED_PERF_EN
    ,
    output logic [31:0]           perf_cycles,
    output logic [31:0]           perf_stalls
`endif
);

    localparam int LW = cw(PE_LAT);

    if (IMG_H != NUM_PE * PE_H) begin : g_bad_geom
        $error("IMG_H must equal NUM_PE*PE_H");
    end

    state_t        state, state_n;
    logic [LW-1:0] wait_cnt;
    logic          last;

    fir_pos_counter #(.W(IMG_W), .H(PE_H), .CW(cw(IMG_W)), .RW(cw(PE_H))) u_pos (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE && start),
        .inc  (state == CAPTURE),
        .col  (col),
        .row  (row),
        .last (last)
    );

    // First window is accepted in the same cycle it shows up.
    assign valid_dmac = tc_set || (state == ISSUE && win_valid);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? LOAD : IDLE;
            LOAD:    state_n = tap_idx == TAP_W'(TAPS - 1) ? ISSUE : LOAD;
            ISSUE:   state_n = win_valid ? WAIT : ISSUE;
            WAIT:    state_n = wait_cnt == '0 ? CAPTURE : WAIT;
            CAPTURE: state_n = last ? DONE : ISSUE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tap_idx  <= '0;
            wait_cnt <= '0;
            tc_set   <= 1'b0;
            out_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            tap_idx  <= (state == LOAD && state_n == LOAD) ? tap_idx + 1'b1 : '0;
            wait_cnt <= state == ISSUE ? LW'(PE_LAT - 1) : wait_cnt - 1'b1;
            tc_set   <= state_n == LOAD;
            out_we   <= state_n == CAPTURE;
            busy     <= state_n inside {LOAD, ISSUE, WAIT, CAPTURE};
            done     <= state_n == DONE;
        end
    end

`ifdef FIR_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start)) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (state != IDLE) begin
            perf_cycles <= perf_cycles + {31'b0, ~&perf_cycles};
            perf_stalls <= perf_stalls + {31'b0, state == ISSUE && !win_valid && ~&perf_stalls};
        end
    end
`endif

endmodule

// File: tb/tb_fir_4pe_scheduler.sv
// tb_fir_4pe_scheduler: directed self-checking bench for fir_4pe_scheduler (PE_LAT=1 and PE_LAT=3 instances)
module tb_fir_4pe_scheduler;

    logic       clk = 1'b0;
    logic       rst, start, win_valid, start1;
    logic       tc_set, valid_dmac, out_we, busy, done;
    logic [3:0] tap_idx;
    logic       row;
    logic [1:0] col;
    logic       tc_set1, valid_dmac1, out_we1, busy1, done1;
    logic [3:0] tap_idx1;
    logic       row1;
    logic [1:0] col1;
`ifdef FIR_SCHED_PERF_EN
    logic [31:0] perf_cycles, perf_stalls, perf_cycles1, perf_stalls1;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    fir_4pe_scheduler #(.IMG_W(4), .IMG_H(8), .NUM_PE(4), .PE_H(2), .TAPS(9), .PE_LAT(1)) u0 (
        .clk(clk), .rst(rst), .start(start), .win_valid(win_valid),
        .tc_set(tc_set), .tap_idx(tap_idx), .valid_dmac(valid_dmac),
        .row(row), .col(col), .out_we(out_we), .busy(busy), .done(done)
`ifdef FIR_SCHED_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
    );

    fir_4pe_scheduler #(.IMG_W(4), .IMG_H(8), .NUM_PE(4), .PE_H(2), .TAPS(9), .PE_LAT(3)) u1 (
        .clk(clk), .rst(rst), .start(start1), .win_valid(1'b1),
        .tc_set(tc_set1), .tap_idx(tap_idx1), .valid_dmac(valid_dmac1),
        .row(row1), .col(col1), .out_we(out_we1), .busy(busy1), .done(done1)
`ifdef FIR_SCHED_PERF_EN
        , .perf_cycles(perf_cycles1), .perf_stalls(perf_stalls1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @c%0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // One frame on u0 with win_valid held low for `stall` cycles at the ISSUE of (1,2),
    // optionally pulsing start during LOAD (c=4) and CAPTURE (c=12). Cycle 0 carries start.
    // Unstalled timeline: LOAD c1..9, pixel p ISSUE/WAIT/CAPTURE at 10+3p.., done at c34.
    task automatic run_frame(input int stall, input bit extra);
        int q, p, ph, last_c;
        last_c = 34 + stall;
        for (int c = 0; c <= last_c + 2; c++) begin
            @(negedge clk);
            start     = (c == 0) || (extra && (c == 4 || c == 12));
            win_valid = !(c >= 28 && c < 28 + stall);
            #1;
            cyc = c;
            if (c >= 28 && c < 28 + stall) begin
                chk("stall_vd", valid_dmac, 0);
                chk("stall_we", out_we, 0);
                chk("stall_busy", busy, 1);
                chk("stall_row", row, 1);
                chk("stall_col", col, 2);
            end else begin
                q = (c >= 28) ? c - stall : c;
                if (q == 0 || q > 34) begin
                    chk("idle_tc", tc_set, 0);
                    chk("idle_tap", tap_idx, 0);
                    chk("idle_vd", valid_dmac, 0);
                    chk("idle_we", out_we, 0);
                    chk("idle_busy", busy, 0);
                    chk("idle_done", done, 0);
                    if (q == 0) begin
                        chk("idle_row", row, 0);
                        chk("idle_col", col, 0);
                    end
                end else if (q <= 9) begin
                    chk("load_tc", tc_set, 1);
                    chk("load_tap", tap_idx, q - 1);
                    chk("load_vd", valid_dmac, 1);
                    chk("load_we", out_we, 0);
                    chk("load_busy", busy, 1);
                    chk("load_done", done, 0);
                end else if (q <= 33) begin
                    p  = (q - 10) / 3;
                    ph = (q - 10) % 3;
                    chk("pix_tc", tc_set, 0);
                    chk("pix_vd", valid_dmac, ph == 0);
                    chk("pix_we", out_we, ph == 2);
                    chk("pix_busy", busy, 1);
                    chk("pix_done", done, 0);
                    chk("pix_row", row, p / 4);
                    chk("pix_col", col, p % 4);
                end else begin
                    chk("done_pulse", done, 1);
                    chk("done_busy", busy, 0);
                    chk("done_we", out_we, 0);
                end
            end
`ifdef FIR_SCHED_PERF_EN
            if (stall == 5 && c == last_c + 1) begin
                chk("perf_cycles", perf_cycles, 39);
                chk("perf_stalls", perf_stalls, 5);
            end
`endif
        end
        start     = 1'b0;
        win_valid = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        start1    = 1'b0;
        win_valid = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        cyc = -1;
        chk("rst_tc", tc_set, 0);
        chk("rst_tap", tap_idx, 0);
        chk("rst_vd", valid_dmac, 0);
        chk("rst_row", row, 0);
        chk("rst_col", col, 0);
        chk("rst_we", out_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        run_frame(0, 1'b0);
        run_frame(5, 1'b0);

        for (int c = 0; c <= 21; c++) begin
            @(negedge clk);
            start = (c == 0);
            rst   = (c == 20);
            #1;
            cyc = 100 + c;
            if (c == 20) begin
                chk("mr_wait_row", row, 0);
                chk("mr_wait_col", col, 3);
                chk("mr_wait_busy", busy, 1);
                chk("mr_wait_we", out_we, 0);
            end
            if (c == 21) begin
                chk("mr_tc", tc_set, 0);
                chk("mr_tap", tap_idx, 0);
                chk("mr_vd", valid_dmac, 0);
                chk("mr_row", row, 0);
                chk("mr_col", col, 0);
                chk("mr_we", out_we, 0);
                chk("mr_busy", busy, 0);
                chk("mr_done", done, 0);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            #1;
            cyc = 122 + c;
            chk("mr_no_done", done, 0);
            chk("mr_no_busy", busy, 0);
        end

        run_frame(0, 1'b0);
        run_frame(0, 1'b1);

        // PE_LAT=3: ISSUE at 10+5p, CAPTURE at 14+5p, done at c50.
        for (int c = 0; c <= 52; c++) begin
            @(negedge clk);
            start1 = (c == 0);
            #1;
            cyc = 200 + c;
            chk("l3_vd", valid_dmac1, (c >= 1 && c <= 9) || (c >= 10 && c < 50 && (c - 10) % 5 == 0));
            chk("l3_we", out_we1, c >= 14 && c < 50 && (c - 14) % 5 == 0);
            chk("l3_done", done1, c == 50);
            chk("l3_busy", busy1, c >= 1 && c <= 49);
            if (c >= 14 && c < 50 && (c - 14) % 5 == 0) begin
                chk("l3_row", row1, ((c - 14) / 5) / 4);
                chk("l3_col", col1, ((c - 14) / 5) % 4);
            end
        end
        start1 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
